register_file_1r_1w_march_bist: RTL and testbench
=================================================

REGISTER_FILE_1R_1W_MARCH_BIST -- requirements
Module: register_file_1r_1w_march_bist

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 5, address bits; depth D = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, 32, word width; multiple of 8.
REQ-003 SHALL have parameter NUM_BYTE, DATA_WIDTH/8, byte-enable count.
REQ-004 SHALL have ports (name, direction, width, meaning): clk, in, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have rst, in, 1; reset is synchronous and active-high.
REQ-006 SHALL have functional read port: ReadEnable in 1; ReadAddr in ADDR_WIDTH; ReadData out DATA_WIDTH.
REQ-007 SHALL have functional write port: WriteEnable in 1; WriteAddr in ADDR_WIDTH; WriteData in DATA_WIDTH; WriteBE in NUM_BYTE.
REQ-008 SHALL have external test port: BIST in 1 (select); CSN_T in 1 (active-low select); WEN_T in 1 (0 = write); A_T in ADDR_WIDTH; D_T in DATA_WIDTH; BE_T in NUM_BYTE; Q_T out DATA_WIDTH.
REQ-009 SHALL have engine port: BistStart in 1 (start pulse); BistBusy out 1; BistDone out 1; BistFail out 1; BistFailAddr out ADDR_WIDTH.

Function
REQ-010 SHALL contain a D x DATA_WIDTH array with byte-granular writes; write commits at clock edge; ReadData is registered, valid the cycle after a read request, held otherwise.
REQ-011 SHALL source array access by priority: engine (BistBusy=1) > test port (BIST=1) > functional ports.
REQ-012 Test port SHALL map: read = !CSN_T && WEN_T; write = !CSN_T && !WEN_T; address A_T; data D_T; enables BE_T.
REQ-013 Q_T SHALL equal ReadData at all times.
REQ-014 Engine states SHALL be IDLE, M0..M5, TAIL, DONE.
REQ-015 BistStart=1 in IDLE or DONE SHALL enter M0 next cycle and clear BistDone, BistFail, BistFailAddr; it SHALL be ignored in all other states.
REQ-016 March elements: M0 up {w0}; M1 up {r0,w1}; M2 up {r1,w0}; M3 down {r0,w1}; M4 down {r1,w0}; M5 down {r0}; "0"/"1" = all-zero/all-one words, all byte enables set.
REQ-017 Each operation SHALL take one cycle; address counter SHALL wrap D-1 -> 0 (up) or 0 -> D-1 (down) at element change.
REQ-018 Each read SHALL be compared the following cycle; M5's last compare SHALL occur in TAIL; BistBusy SHALL be high exactly 10*D+1 cycles.
REQ-019 On first mismatch BistFail SHALL set (sticky) and BistFailAddr SHALL capture that read's address; later mismatches SHALL not update it; the run SHALL continue to completion.
REQ-020 After TAIL the engine SHALL enter DONE: BistBusy=0, BistDone=1, held until BistStart or rst.
REQ-021 Functional/test-port requests during BistBusy SHALL be dropped without effect; array content after a run is all-zero.

Reset
REQ-022 rst=1 SHALL force IDLE; BistBusy, BistDone, BistFail=0; BistFailAddr=0; ReadData=0.
REQ-023 rst mid-run SHALL abort the engine next edge; array content SHALL be undefined and not cleared.
REQ-024 rst SHALL take precedence over simultaneous BistStart.

Configuration
REQ-025 Macro SCM_MARCH_BIST_EN defined SHALL include the engine per REQ-014..021.
REQ-026 Without SCM_MARCH_BIST_EN the engine SHALL be absent: BistStart ignored, BistBusy/BistDone/BistFail/BistFailAddr tied 0, priority is test port > functional.

Verification (ADDR_WIDTH=2, DATA_WIDTH=32)
REQ-027 Functional write 0xDEADBEEF, WriteBE=4'b0101, addr 1 over 0 -> read addr 1 gives 0x00AD00EF one cycle later.
REQ-028 BIST=1, CSN_T=0, WEN_T=0, A_T=3, D_T=0x12345678, BE_T=4'hF; then WEN_T=1 -> Q_T=0x12345678; simultaneous functional write to addr 3 has no effect.
REQ-029 BistStart pulse in IDLE -> BistBusy high 41 cycles, then BistDone=1, BistFail=0; all four addresses read 0.
REQ-030 Force stored bit 3 of addr 2 stuck-at-1 -> BistFail=1, BistFailAddr=2 after first failing compare (M1), unchanged at BistDone.
REQ-031 rst=1 at cycle 20 of a run -> next cycle all engine outputs 0, state IDLE; new BistStart runs full 41 cycles.
REQ-032 Build without SCM_MARCH_BIST_EN, pulse BistStart -> BistBusy stays 0; REQ-027/028 still pass.

Source files
------------

// File: rtl/register_file_1r_1w_march_bist.sv
// -----------------------------------------------------------------------------
// register_file_1r_1w_march_bist
//
// D x DATA_WIDTH register file (D = 2**ADDR_WIDTH) with one registered read
// port, one byte-maskable write port, an external test port and an optional
// built-in March C- style self-test engine.
//
// Array access priority: engine (while BistBusy) > test port (BIST=1) >
// functional ports. Requests that lose arbitration are dropped.
//
// Optional feature macro: SCM_MARCH_BIST_EN
//   defined   : March engine present (M0 up w0, M1 up r0w1, M2 up r1w0,
//               M3 down r0w1, M4 down r1w0, M5 down r0, then TAIL, DONE).
//   undefined : engine absent, BistStart ignored, Bist* outputs tied to 0.
//
// Ports
//   clk, rst                          rising-edge clock, sync active-high reset
//   ReadEnable/ReadAddr/ReadData      functional read (data valid next cycle, held)
//   WriteEnable/WriteAddr/WriteData/WriteBE  functional byte-masked write
//   BIST/CSN_T/WEN_T/A_T/D_T/BE_T/Q_T test port (CSN_T low selects, WEN_T low writes)
//   BistStart/BistBusy/BistDone/BistFail/BistFailAddr  self-test engine control/status
// -----------------------------------------------------------------------------
module register_file_1r_1w_march_bist #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // functional read port
   input  logic                  ReadEnable,
   input  logic [ADDR_WIDTH-1:0] ReadAddr,
   output logic [DATA_WIDTH-1:0] ReadData,
   // functional write port
   input  logic                  WriteEnable,
   input  logic [ADDR_WIDTH-1:0] WriteAddr,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [NUM_BYTE-1:0]   WriteBE,
   // external test port
   input  logic                  BIST,
   input  logic                  CSN_T,
   input  logic                  WEN_T,
   input  logic [ADDR_WIDTH-1:0] A_T,
   input  logic [DATA_WIDTH-1:0] D_T,
   input  logic [NUM_BYTE-1:0]   BE_T,
   output logic [DATA_WIDTH-1:0] Q_T,
   // self-test engine
   input  logic                  BistStart,
   output logic                  BistBusy,
   output logic                  BistDone,
   output logic                  BistFail,
   output logic [ADDR_WIDTH-1:0] BistFailAddr
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Engine request into the array mux (constant 0 when the engine is absent).
   logic                  eng_busy;
   logic                  eng_rd;
   logic                  eng_wr;
   logic                  eng_val;   // 0 = all-zero word, 1 = all-one word
   logic [ADDR_WIDTH-1:0] eng_addr;

   // Arbitrated array access.
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_BYTE-1:0]   wr_be;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: every output of a combinational block gets a default first so that
   // no path through the branches leaves a value unassigned (no latches).
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_be   = '0;
      if (eng_busy) begin
         rd_en   = eng_rd;
         rd_addr = eng_addr;
         wr_en   = eng_wr;
         wr_addr = eng_addr;
         wr_data = {DATA_WIDTH{eng_val}};
         wr_be   = '1;
      end else if (BIST) begin
         rd_en   = !CSN_T && WEN_T;
         rd_addr = A_T;
         wr_en   = !CSN_T && !WEN_T;
         wr_addr = A_T;
         wr_data = D_T;
         wr_be   = BE_T;
      end else begin
         rd_en   = ReadEnable;
         rd_addr = ReadAddr;
         wr_en   = WriteEnable;
         wr_addr = WriteAddr;
         wr_data = WriteData;
         wr_be   = WriteBE;
      end
   end

   // NOTE: the storage array has no reset; its content is undefined after rst
   // and only the engine (or explicit writes) give it a known value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NUM_BYTE; b++) begin
            if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // Registered read data: updated only on an accepted read, held otherwise.
   // A read and write to the same address in one cycle returns the old word.
   always_ff @(posedge clk) begin
      if (rst)        ReadData <= '0;
      else if (rd_en) ReadData <= mem[rd_addr];
   end

   assign Q_T = ReadData;

`ifdef SCM_MARCH_BIST_EN

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_TAIL, S_DONE
   } bist_state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   bist_state_t           state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic                  phase, phase_nxt;   // 0 = read op, 1 = write op (two-op elements)
   logic                  addr_done;          // last operation at the current address
   logic                  down;
   logic                  last_addr;
   logic                  start_ok;
   logic                  cmp_valid;
   logic                  cmp_val;
   logic [ADDR_WIDTH-1:0] cmp_addr;
   logic                  fail;
   logic [ADDR_WIDTH-1:0] fail_addr;

   assign start_ok  = (state == S_IDLE || state == S_DONE) && BistStart;
   assign eng_busy  = !(state == S_IDLE || state == S_DONE);
   assign down      = state inside {S_M3, S_M4, S_M5};
   assign last_addr = down ? (eng_addr == '0) : (eng_addr == ADDR_MAX);

   always_comb begin
      state_nxt = state;
      addr_nxt  = eng_addr;
      phase_nxt = phase;
      eng_rd    = 1'b0;
      eng_wr    = 1'b0;
      eng_val   = 1'b0;
      addr_done = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (BistStart) begin
               state_nxt = S_M0;
               addr_nxt  = '0;
               phase_nxt = 1'b0;
            end
         end
         S_M0: begin                       // w0
            eng_wr    = 1'b1;
            addr_done = 1'b1;
         end
         S_M1, S_M3: begin                 // r0, w1
            eng_rd    = !phase;
            eng_wr    = phase;
            eng_val   = phase;
            phase_nxt = !phase;
            addr_done = phase;
         end
         S_M2, S_M4: begin                 // r1, w0
            eng_rd    = !phase;
            eng_wr    = phase;
            eng_val   = !phase;
            phase_nxt = !phase;
            addr_done = phase;
         end
         S_M5: begin                       // r0
            eng_rd    = 1'b1;
            addr_done = 1'b1;
         end
         S_TAIL:  state_nxt = S_DONE;      // M5's final compare happens here
         default: state_nxt = S_IDLE;
      endcase

      if (addr_done) begin
         addr_nxt = down ? eng_addr - ADDR_WIDTH'(1) : eng_addr + ADDR_WIDTH'(1);
         if (last_addr) begin
            // Elements run in enum order; M3..M5 start from the top address.
            state_nxt = bist_state_t'(state + 4'd1);
            addr_nxt  = (state inside {S_M2, S_M3, S_M4}) ? ADDR_MAX : '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         eng_addr  <= '0;
         phase     <= 1'b0;
         cmp_valid <= 1'b0;
         cmp_val   <= 1'b0;
         cmp_addr  <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
      end else begin
         state     <= state_nxt;
         eng_addr  <= addr_nxt;
         phase     <= phase_nxt;
         // An engine read lands in ReadData at this edge and is checked next cycle.
         cmp_valid <= eng_rd;
         cmp_val   <= eng_val;
         cmp_addr  <= eng_addr;
         if (start_ok) begin
            fail      <= 1'b0;
            fail_addr <= '0;
         end else if (cmp_valid && !fail && (ReadData != {DATA_WIDTH{cmp_val}})) begin
            fail      <= 1'b1;
            fail_addr <= cmp_addr;
         end
      end
   end

   assign BistBusy     = eng_busy;
   assign BistDone     = (state == S_DONE);
   assign BistFail     = fail;
   assign BistFailAddr = fail_addr;

`else

   wire unused_bist_start = BistStart;

   assign eng_busy     = 1'b0;
   assign eng_rd       = 1'b0;
   assign eng_wr       = 1'b0;
   assign eng_val      = 1'b0;
   assign eng_addr     = '0;
   assign BistBusy     = 1'b0;
   assign BistDone     = 1'b0;
   assign BistFail     = 1'b0;
   assign BistFailAddr = '0;

`endif

endmodule

// File: tb/tb_register_file_1r_1w_march_bist.sv
// -----------------------------------------------------------------------------
// Bench for register_file_1r_1w_march_bist (ADDR_WIDTH=2, DATA_WIDTH=32).
// A driver issues directed and random requests and pushes the expected read
// word (from an array model of the register file) into a queue; a monitor pops
// and compares whenever a read result is due. Engine runs are checked when the
// build defines SCM_MARCH_BIST_EN; otherwise the engine must stay inert.
// -----------------------------------------------------------------------------
module tb_register_file_1r_1w_march_bist;

   localparam int AW = 2;
   localparam int DW = 32;
   localparam int NB = DW / 8;
   localparam int D  = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          ReadEnable;
   logic [AW-1:0] ReadAddr;
   logic [DW-1:0] ReadData;
   logic          WriteEnable;
   logic [AW-1:0] WriteAddr;
   logic [DW-1:0] WriteData;
   logic [NB-1:0] WriteBE;
   logic          BIST;
   logic          CSN_T;
   logic          WEN_T;
   logic [AW-1:0] A_T;
   logic [DW-1:0] D_T;
   logic [NB-1:0] BE_T;
   logic [DW-1:0] Q_T;
   logic          BistStart;
   logic          BistBusy;
   logic          BistDone;
   logic          BistFail;
   logic [AW-1:0] BistFailAddr;

   always #5 clk = ~clk;

   register_file_1r_1w_march_bist #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ReadEnable  (ReadEnable),
      .ReadAddr    (ReadAddr),
      .ReadData    (ReadData),
      .WriteEnable (WriteEnable),
      .WriteAddr   (WriteAddr),
      .WriteData   (WriteData),
      .WriteBE     (WriteBE),
      .BIST        (BIST),
      .CSN_T       (CSN_T),
      .WEN_T       (WEN_T),
      .A_T         (A_T),
      .D_T         (D_T),
      .BE_T        (BE_T),
      .Q_T         (Q_T),
      .BistStart   (BistStart),
      .BistBusy    (BistBusy),
      .BistDone    (BistDone),
      .BistFail    (BistFail),
      .BistFailAddr(BistFailAddr)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] model [D];
   logic [DW-1:0] exp_q [$];
   bit            exp_fire = 1'b0;   // a read result is due after the coming edge
   bit            hold_chk = 1'b0;   // ReadData must hold when no read is due

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin : monitor
      logic [DW-1:0] last_q;
      logic [DW-1:0] e;
      bit            f, h, r;
      last_q = '0;
      forever begin
         @(posedge clk);
         f = exp_fire;
         h = hold_chk;
         r = rst;
         #1;
         if (r) begin
            check("readdata_reset", ReadData, '0);
            last_q = '0;
         end else if (f) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL scoreboard_underflow: read due but no expected value queued");
            end else begin
               e = exp_q.pop_front();
               check("read_data", ReadData, e);
               last_q = e;
            end
         end else if (h) begin
            check("read_hold", ReadData, last_q);
         end
         if (f || h || r) check("q_t_mirror", Q_T, ReadData);
      end
   end

   initial begin : watchdog
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      ReadEnable  = 1'b0;
      ReadAddr    = '0;
      WriteEnable = 1'b0;
      WriteAddr   = '0;
      WriteData   = '0;
      WriteBE     = '0;
      BIST        = 1'b0;
      CSN_T       = 1'b1;
      WEN_T       = 1'b1;
      A_T         = '0;
      D_T         = '0;
      BE_T        = '0;
   endtask

   // Apply the currently driven inputs to the model (engine idle), queue any
   // read result, then advance to the next falling edge.
   task automatic step();
      bit            rd, wr;
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] wd;
      logic [NB-1:0] be;
      if (BIST) begin
         rd = !CSN_T && WEN_T;
         wr = !CSN_T && !WEN_T;
         ra = A_T;
         wa = A_T;
         wd = D_T;
         be = BE_T;
      end else begin
         rd = ReadEnable;
         wr = WriteEnable;
         ra = ReadAddr;
         wa = WriteAddr;
         wd = WriteData;
         be = WriteBE;
      end
      exp_fire = rd && !rst;
      if (rd && !rst) exp_q.push_back(model[ra]);
      if (wr && !rst) begin
         for (int b = 0; b < NB; b++) if (be[b]) model[wa][b*8 +: 8] = wd[b*8 +: 8];
      end
      @(negedge clk);
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      idle();
      WriteEnable = 1'b1;
      WriteAddr   = a;
      WriteData   = d;
      WriteBE     = '1;
      step();
      idle();
   endtask

   task automatic read_all();
      for (int a = 0; a < D; a++) begin
         idle();
         ReadEnable = 1'b1;
         ReadAddr   = AW'(a);
         step();
      end
      idle();
   endtask

   task automatic random_inputs(input bit with_start);
      BIST        = 1'($urandom_range(0, 1));
      CSN_T       = ($urandom_range(0, 3) == 0);
      WEN_T       = 1'($urandom_range(0, 1));
      A_T         = AW'($urandom_range(0, D - 1));
      D_T         = $urandom;
      BE_T        = NB'($urandom_range(0, 15));
      ReadEnable  = 1'($urandom_range(0, 1));
      ReadAddr    = AW'($urandom_range(0, D - 1));
      WriteEnable = 1'($urandom_range(0, 1));
      WriteAddr   = AW'($urandom_range(0, D - 1));
      WriteData   = $urandom;
      WriteBE     = NB'($urandom_range(0, 15));
      if (with_start) BistStart = ($urandom_range(0, 7) == 0);
   endtask

`ifdef SCM_MARCH_BIST_EN
   // One engine run with junk requests on both ports (all must be dropped).
   // fault=1 plants a stuck bit in addr 2 before M1 reads it and a second
   // error in addr 1 before M3 reads it. rst_at>=0 resets at that busy cycle.
   task automatic bist_run(input bit fault, input int rst_at, output int busy);
      hold_chk  = 1'b0;
      exp_fire  = 1'b0;
      idle();
      BistStart = 1'b1;
      @(negedge clk);
      BistStart = 1'b0;
      busy = 0;
      for (int c = 0; c < 300; c++) begin
         if (rst_at >= 0 && c == rst_at + 1) begin
            check("abort_busy", BistBusy, 0);
            check("abort_done", BistDone, 0);
            check("abort_fail", BistFail, 0);
            check("abort_fail_addr", BistFailAddr, 0);
            rst = 1'b0;
            break;
         end
         if (c == 0) begin
            check("start_clears_done", BistDone, 0);
            check("start_clears_fail", BistFail, 0);
            check("start_clears_fail_addr", BistFailAddr, 0);
         end
         if (BistBusy) busy++;
         else break;
         random_inputs(1'b1);
         if (fault && c == 6)  dut.mem[2] = 32'h0000_0008;
         if (fault && c == 9)  check("fail_not_before_m1_compare", BistFail, 0);
         if (fault && c == 10) begin
            check("fail_set_m1", BistFail, 1);
            check("fail_addr_m1", BistFailAddr, 2);
         end
         if (fault && c == 22) dut.mem[1] = 32'h0000_0001;
         if (c == rst_at) begin
            rst       = 1'b1;
            BistStart = 1'b1;   // reset must win over a simultaneous start
         end
         @(negedge clk);
      end
      BistStart = 1'b0;
      idle();
   endtask
`endif

   initial begin : main
      int busy;
      int seen;
      rst       = 1'b1;
      BistStart = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      check("reset_busy", BistBusy, 0);
      check("reset_done", BistDone, 0);
      check("reset_fail", BistFail, 0);
      check("reset_fail_addr", BistFailAddr, 0);
      check("reset_readdata_direct", ReadData, 0);
      rst      = 1'b0;
      hold_chk = 1'b1;

      // Known starting content.
      for (int a = 0; a < D; a++) write_word(AW'(a), '0);

      // Byte-masked write over zero.
      idle();
      WriteEnable = 1'b1;
      WriteAddr   = 2'd1;
      WriteData   = 32'hDEAD_BEEF;
      WriteBE     = 4'b0101;
      step();
      idle();
      ReadEnable = 1'b1;
      ReadAddr   = 2'd1;
      step();
      idle();
      check("byte_enable_merge", ReadData, 32'h00AD_00EF);

      // Test-port write/read with a competing functional write to the same word.
      BIST        = 1'b1;
      CSN_T       = 1'b0;
      WEN_T       = 1'b0;
      A_T         = 2'd3;
      D_T         = 32'h1234_5678;
      BE_T        = 4'hF;
      WriteEnable = 1'b1;
      WriteAddr   = 2'd3;
      WriteData   = 32'hFFFF_FFFF;
      WriteBE     = 4'hF;
      step();
      WEN_T = 1'b1;
      step();
      idle();
      check("test_port_q_t", Q_T, 32'h1234_5678);
      ReadEnable = 1'b1;
      ReadAddr   = 2'd3;
      step();
      idle();
      check("functional_write_blocked", ReadData, 32'h1234_5678);

      // Random traffic on both ports.
      for (int i = 0; i < 400; i++) begin
         random_inputs(1'b0);
         step();
      end
      idle();
      step();

`ifdef SCM_MARCH_BIST_EN
      // Clean run.
      bist_run(1'b0, -1, busy);
      check("busy_cycles_clean", busy, 10 * D + 1);
      check("done_clean", BistDone, 1);
      check("fail_clean", BistFail, 0);
      for (int a = 0; a < D; a++) model[a] = '0;
      read_all();
      hold_chk = 1'b1;
      step();
      check("done_held", BistDone, 1);

      // Run with planted faults: first failure (addr 2) is sticky.
      bist_run(1'b1, -1, busy);
      check("busy_cycles_fault", busy, 10 * D + 1);
      check("done_fault", BistDone, 1);
      check("fail_sticky", BistFail, 1);
      check("fail_addr_first_only", BistFailAddr, 2);
      for (int a = 0; a < D; a++) model[a] = '0;
      read_all();
      hold_chk = 1'b1;
      step();

      // Restart from DONE clears status; then abort with reset at busy cycle 20.
      bist_run(1'b0, 20, busy);
      check("busy_before_abort", busy, 21);
      idle();
      hold_chk = 1'b1;
      step();
      for (int a = 0; a < D; a++) write_word(AW'(a), $urandom);
      bist_run(1'b0, -1, busy);
      check("busy_cycles_after_abort", busy, 10 * D + 1);
      check("done_after_abort", BistDone, 1);
      check("fail_after_abort", BistFail, 0);
      for (int a = 0; a < D; a++) model[a] = '0;
      read_all();
      hold_chk = 1'b1;
      step();
`else
      // Engine absent: a start pulse must have no visible effect.
      BistStart = 1'b1;
      step();
      BistStart = 1'b0;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         if (BistBusy) seen++;
         step();
      end
      check("busy_without_engine", seen, 0);
      check("done_without_engine", BistDone, 0);
      check("fail_without_engine", BistFail, 0);
      check("fail_addr_without_engine", BistFailAddr, 0);
`endif

      // ReadData clears on reset even when it held a non-zero word.
      write_word(2'd0, 32'hA5A5_A5A5);
      ReadEnable = 1'b1;
      ReadAddr   = 2'd0;
      step();
      idle();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("readdata_after_reset", ReadData, 0);
      check("done_after_reset", BistDone, 0);
      step();
      step();
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
